// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: opcodes, funct7 values and the decoded-instruction records
// control_info carries one flag per recognised op plus rd, immediate and pc;
// decoded_entry adds the source indices and the illegal marker.
package decode_stage_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  typedef struct packed {
    logic lui, auipc, jal, jalr;
    logic beq, bne, blt, bge, bltu, bgeu;
    logic lb, lh, lw, lbu, lhu;
    logic sb, sh, sw;
    logic addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
    logic add, sub, sll, slt, sltu, op_xor, srl, sra, op_or, op_and;
    logic mul, mulh, mulhsu, mulhu, div, divu, rem, remu;
    logic [4:0]  rd;
    logic [31:0] immediate;
    logic [31:0] pc;
  } control_info;
  typedef struct packed {
    control_info ctr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;
  } decoded_entry;
endpackage

// File: rtl/decode_stage_comb.sv
// decode_comb: combinational RV32I/M instruction + pc to decoded_entry
// Ports: instr/pc in, dec out. ENABLE_M=0 makes RV32M encodings illegal.
module decode_comb import decode_stage_pkg::*; #(
  parameter int ENABLE_M = 1
) (
  input  logic [31:0]  instr,
  input  logic [31:0]  pc,
  output decoded_entry dec
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic r_t, i_t, s_t, b_t, u_t, j_t, opi, rb, ra, m_ok, ill;
  logic [31:0] imm;
  control_info c;
  always_comb begin
    op = instr[6:0];
    r_t = op == OP_REG;
    i_t = op == OP_JALR || op == OP_LOAD || op == OP_IMM;
    s_t = op == OP_STORE;
    b_t = op == OP_BRANCH;
    u_t = op == OP_LUI || op == OP_AUIPC;
    j_t = op == OP_JAL;
    opi = op == OP_IMM;
    f3 = (r_t | i_t | s_t | b_t) ? instr[14:12] : 3'd0;
    f7 = r_t ? instr[31:25] : 7'd0;
    imm = i_t ? {{20{instr[31]}}, instr[31:20]}
        : s_t ? {{20{instr[31]}}, instr[31:25], instr[11:7]}
        : b_t ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0}
        : u_t ? {instr[31:12], 12'b0}
        : j_t ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0}
        : 32'd0;
    rb = r_t && f7 == F7_BASE;
    ra = r_t && f7 == F7_ALT;
    m_ok = (ENABLE_M != 0) && r_t && f7 == F7_MULDIV;
    c = '0;
    c.lui = op == OP_LUI;
    c.auipc = op == OP_AUIPC;
    c.jal = j_t;
    c.jalr = op == OP_JALR && f3 == 3'd0;
    c.beq = b_t && f3 == 3'd0;
    c.bne = b_t && f3 == 3'd1;
    c.blt = b_t && f3 == 3'd4;
    c.bge = b_t && f3 == 3'd5;
    c.bltu = b_t && f3 == 3'd6;
    c.bgeu = b_t && f3 == 3'd7;
    c.lb = op == OP_LOAD && f3 == 3'd0;
    c.lh = op == OP_LOAD && f3 == 3'd1;
    c.lw = op == OP_LOAD && f3 == 3'd2;
    c.lbu = op == OP_LOAD && f3 == 3'd4;
    c.lhu = op == OP_LOAD && f3 == 3'd5;
    c.sb = s_t && f3 == 3'd0;
    c.sh = s_t && f3 == 3'd1;
    c.sw = s_t && f3 == 3'd2;
    c.addi = opi && f3 == 3'd0;
    c.slti = opi && f3 == 3'd2;
    c.sltiu = opi && f3 == 3'd3;
    c.xori = opi && f3 == 3'd4;
    c.ori = opi && f3 == 3'd6;
    c.andi = opi && f3 == 3'd7;
    // f7 is masked for I-type, so shift-immediates look at the raw upper bits
    c.slli = opi && f3 == 3'd1 && instr[31:25] == F7_BASE;
    c.srli = opi && f3 == 3'd5 && instr[31:25] == F7_BASE;
    c.srai = opi && f3 == 3'd5 && instr[31:25] == F7_ALT;
    c.add = rb && f3 == 3'd0;
    c.sub = ra && f3 == 3'd0;
    c.sll = rb && f3 == 3'd1;
    c.slt = rb && f3 == 3'd2;
    c.sltu = rb && f3 == 3'd3;
    c.op_xor = rb && f3 == 3'd4;
    c.srl = rb && f3 == 3'd5;
    c.sra = ra && f3 == 3'd5;
    c.op_or = rb && f3 == 3'd6;
    c.op_and = rb && f3 == 3'd7;
    c.mul = m_ok && f3 == 3'd0;
    c.mulh = m_ok && f3 == 3'd1;
    c.mulhsu = m_ok && f3 == 3'd2;
    c.mulhu = m_ok && f3 == 3'd3;
    c.div = m_ok && f3 == 3'd4;
    c.divu = m_ok && f3 == 3'd5;
    c.rem = m_ok && f3 == 3'd6;
    c.remu = m_ok && f3 == 3'd7;
    // only flags are set so far, so any set bit means a recognised op
    ill = ~|c;
    c.rd = (!ill && (r_t | i_t | u_t | j_t)) ? instr[11:7] : 5'd0;
    c.immediate = imm;
    c.pc = pc;
    dec.ctr = c;
    dec.rs1 = (r_t | i_t | s_t | b_t) ? instr[19:15] : 5'd0;
    dec.rs2 = (r_t | s_t | b_t) ? instr[24:20] : 5'd0;
    dec.illegal = ill;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: valid/ready decode stage with optional skid entry, flush and saturating counter
// Ports: CLK/RST, fetch side IN_VALID/IN_READY/IN_INSTR/IN_PC, FLUSH,
// downstream OUT_VALID/OUT_READY/OUT_CTR/OUT_RS1/OUT_RS2/OUT_ILLEGAL, DEC_COUNT.
module decode_stage import decode_stage_pkg::*; #(
  parameter int ENABLE_M = 1,
  parameter int SKID     = 1,
  parameter int CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [31:0]       IN_INSTR,
  input  logic [31:0]       IN_PC,
  input  logic              FLUSH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output control_info       OUT_CTR,
  output logic [4:0]        OUT_RS1,
  output logic [4:0]        OUT_RS2,
  output logic              OUT_ILLEGAL,
  output logic [CNT_W-1:0]  DEC_COUNT
);
  decoded_entry dec, main_q, main_d, skid_q, skid_d;
  logic main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic main_free, acc, to_skid;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  decode_comb #(.ENABLE_M(ENABLE_M)) u_dec (.instr(IN_INSTR), .pc(IN_PC), .dec(dec));
  always_comb begin
    main_free = !main_valid_q | OUT_READY;
    IN_READY = !RST & ((SKID != 0) ? !skid_valid_q : main_free);
    acc = IN_VALID & IN_READY;
    // new entry lands in skid when main stays occupied (or is refilled from skid)
    to_skid = (SKID != 0) & acc & (skid_valid_q | !main_free);
    main_valid_d = !FLUSH & (!main_free | skid_valid_q | acc);
    skid_valid_d = !FLUSH & (to_skid | (skid_valid_q & !main_free));
    main_d = !main_free ? main_q : skid_valid_q ? skid_q : acc ? dec : main_q;
    skid_d = to_skid ? dec : skid_q;
    cnt_d = (main_valid_q & OUT_READY & !FLUSH & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      main_q <= '0;
      skid_q <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q <= cnt_d;
    end
  end
  assign OUT_VALID = main_valid_q;
  assign OUT_CTR = main_q.ctr;
  assign OUT_RS1 = main_q.rs1;
  assign OUT_RS2 = main_q.rs2;
  assign OUT_ILLEGAL = main_q.illegal;
  assign DEC_COUNT = cnt_q;
endmodule
